// File: rtl/lcd_init_seq.sv
// Table-driven ST77xx SPI-LCD power-up sequencer: hardware reset, sleep-out,
// external command/data/delay table, then offset window setup and colour fill.
module lcd_init_seq #(
   parameter int RST_LOW_CYC  = 1_000_000,
   parameter int RST_HIGH_CYC = 1_000_000,
   parameter int SLPOUT_CYC   = 250_000,
   parameter int DLY_UNIT_CYC = 50_000,
   parameter int TBL_LEN      = 128,
   parameter int WIDTH        = 128,
   parameter int HEIGHT       = 160,
   parameter int X_OFS        = 2,
   parameter int Y_OFS        = 1
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       wr_done,
   output logic [$clog2(TBL_LEN)-1:0] tbl_addr,
   input  logic [9:0]                 tbl_data,
   input  logic [15:0]                clr_color,
   input  logic                       reinit,
   input  logic                       clr_req,
   output logic                       lcd_rst,
   output logic [8:0]                 init_data,
   output logic                       en_write,
   output logic                       busy,
   output logic                       init_done
);

   localparam int AW         = $clog2(TBL_LEN);
   localparam int NPIX_BYTES = 2 * WIDTH * HEIGHT;
   localparam int PIX_W      = $clog2(NPIX_BYTES + 1);
   localparam int DLY_MAX    = 255 * DLY_UNIT_CYC;
   localparam int MAX_A      = (RST_LOW_CYC > RST_HIGH_CYC) ? RST_LOW_CYC : RST_HIGH_CYC;
   localparam int MAX_B      = (MAX_A > SLPOUT_CYC) ? MAX_A : SLPOUT_CYC;
   localparam int CNT_MAX    = (MAX_B > DLY_MAX) ? MAX_B : DLY_MAX;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [15:0] XS = 16'(X_OFS);
   localparam logic [15:0] XE = 16'(X_OFS + WIDTH - 1);
   localparam logic [15:0] YS = 16'(Y_OFS);
   localparam logic [15:0] YE = 16'(Y_OFS + HEIGHT - 1);

   typedef enum logic [3:0] {
      ST_RST_LOW  = 4'd0,
      ST_RST_HIGH = 4'd1,
      ST_SLPOUT   = 4'd2,
      ST_SLP_WAIT = 4'd3,
      ST_FETCH    = 4'd4,
      ST_ISSUE    = 4'd5,
      ST_TDLY     = 4'd6,
      ST_WIN      = 4'd7,
      ST_FILL     = 4'd8,
      ST_DONE     = 4'd9
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] dly_tgt_q;
   logic [AW-1:0]    tbl_addr_q;
   logic             fetch_ph_q;
   logic [3:0]       win_idx_q;
   logic [PIX_W-1:0] pix_cnt_q;
   logic [15:0]      color_q;
   logic             lcd_rst_q;
   logic [8:0]       init_data_q;
   logic             en_write_q;
   logic             busy_q;
   logic             init_done_q;

   logic [8:0]       win_byte_d;
   logic [8:0]       pix_byte_d;
   logic             wr_ack_s;
   logic             tbl_last_s;
   logic             pix_last_s;

   assign wr_ack_s   = en_write_q & wr_done;
   assign tbl_last_s = (tbl_addr_q == AW'(TBL_LEN - 1));
   assign pix_last_s = (pix_cnt_q == PIX_W'(NPIX_BYTES - 1));

   // Window-setup byte selected by the current window step.
   always_comb begin
      win_byte_d = 9'h100;
      case (win_idx_q)
         4'd0:    win_byte_d = 9'h02A;
         4'd1:    win_byte_d = {1'b1, XS[15:8]};
         4'd2:    win_byte_d = {1'b1, XS[7:0]};
         4'd3:    win_byte_d = {1'b1, XE[15:8]};
         4'd4:    win_byte_d = {1'b1, XE[7:0]};
         4'd5:    win_byte_d = 9'h02B;
         4'd6:    win_byte_d = {1'b1, YS[15:8]};
         4'd7:    win_byte_d = {1'b1, YS[7:0]};
         4'd8:    win_byte_d = {1'b1, YE[15:8]};
         4'd9:    win_byte_d = {1'b1, YE[7:0]};
         4'd10:   win_byte_d = 9'h02C;
         default: win_byte_d = 9'h100;
      endcase
   end

   // Even byte counts carry the colour high byte, odd counts the low byte.
   always_comb begin
      pix_byte_d = 9'h100;
      if (pix_cnt_q[0]) begin
         pix_byte_d = {1'b1, color_q[7:0]};
      end else begin
         pix_byte_d = {1'b1, color_q[15:8]};
      end
   end

   // Sequencer state, counters and all registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_RST_LOW;
         cnt_q       <= '0;
         dly_tgt_q   <= '0;
         tbl_addr_q  <= '0;
         fetch_ph_q  <= 1'b0;
         win_idx_q   <= 4'd0;
         pix_cnt_q   <= '0;
         color_q     <= 16'h0000;
         lcd_rst_q   <= 1'b0;
         init_data_q <= 9'h100;
         en_write_q  <= 1'b0;
         busy_q      <= 1'b1;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RST_LOW: begin
               if ((cnt_q + CNT_W'(1)) >= CNT_W'(RST_LOW_CYC)) begin
                  state_q   <= ST_RST_HIGH;
                  lcd_rst_q <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RST_HIGH: begin
               if ((cnt_q + CNT_W'(1)) >= CNT_W'(RST_HIGH_CYC)) begin
                  state_q <= ST_SLPOUT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_SLPOUT: begin
               if (!en_write_q) begin
                  init_data_q <= 9'h011;
                  en_write_q  <= 1'b1;
               end else if (wr_done) begin
                  en_write_q <= 1'b0;
                  state_q    <= ST_SLP_WAIT;
                  cnt_q      <= '0;
               end else begin
                  en_write_q <= 1'b1;
               end
            end
            ST_SLP_WAIT: begin
               if ((cnt_q + CNT_W'(1)) >= CNT_W'(SLPOUT_CYC)) begin
                  state_q    <= ST_FETCH;
                  tbl_addr_q <= '0;
                  fetch_ph_q <= 1'b0;
                  cnt_q      <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_FETCH: begin
               // Phase 0 lets the ROM answer; phase 1 consumes its data.
               if (!fetch_ph_q) begin
                  fetch_ph_q <= 1'b1;
               end else begin
                  fetch_ph_q <= 1'b0;
                  case (tbl_data[9:8])
                     2'b00: begin
                        init_data_q <= {1'b0, tbl_data[7:0]};
                        en_write_q  <= 1'b1;
                        state_q     <= ST_ISSUE;
                     end
                     2'b01: begin
                        init_data_q <= {1'b1, tbl_data[7:0]};
                        en_write_q  <= 1'b1;
                        state_q     <= ST_ISSUE;
                     end
                     2'b10: begin
                        dly_tgt_q <= CNT_W'(tbl_data[7:0]) * CNT_W'(DLY_UNIT_CYC);
                        cnt_q     <= '0;
                        state_q   <= ST_TDLY;
                     end
                     default: begin
                        state_q <= ST_WIN;
                     end
                  endcase
               end
            end
            ST_ISSUE: begin
               if (wr_ack_s) begin
                  en_write_q <= 1'b0;
                  if (tbl_last_s) begin
                     state_q <= ST_WIN;
                  end else begin
                     tbl_addr_q <= tbl_addr_q + AW'(1);
                     state_q    <= ST_FETCH;
                  end
               end else begin
                  en_write_q <= 1'b1;
               end
            end
            ST_TDLY: begin
               if (cnt_q >= dly_tgt_q) begin
                  cnt_q <= '0;
                  if (tbl_last_s) begin
                     state_q <= ST_WIN;
                  end else begin
                     tbl_addr_q <= tbl_addr_q + AW'(1);
                     state_q    <= ST_FETCH;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_WIN: begin
               if (!en_write_q) begin
                  if (win_idx_q == 4'd0) begin
                     color_q <= clr_color;
                  end else begin
                     color_q <= color_q;
                  end
                  init_data_q <= win_byte_d;
                  en_write_q  <= 1'b1;
               end else if (wr_done) begin
                  en_write_q <= 1'b0;
                  if (win_idx_q == 4'd10) begin
                     win_idx_q <= 4'd0;
                     pix_cnt_q <= '0;
                     state_q   <= ST_FILL;
                  end else begin
                     win_idx_q <= win_idx_q + 4'd1;
                  end
               end else begin
                  en_write_q <= 1'b1;
               end
            end
            ST_FILL: begin
               if (!en_write_q) begin
                  init_data_q <= pix_byte_d;
                  en_write_q  <= 1'b1;
               end else if (wr_done) begin
                  en_write_q <= 1'b0;
                  if (pix_last_s) begin
                     pix_cnt_q   <= '0;
                     state_q     <= ST_DONE;
                     busy_q      <= 1'b0;
                     init_done_q <= 1'b1;
                  end else begin
                     pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                  end
               end else begin
                  en_write_q <= 1'b1;
               end
            end
            ST_DONE: begin
               en_write_q <= 1'b0;
               // A simultaneous reinit overrides a clear request.
               if (reinit) begin
                  state_q     <= ST_RST_LOW;
                  lcd_rst_q   <= 1'b0;
                  cnt_q       <= '0;
                  tbl_addr_q  <= '0;
                  init_data_q <= 9'h100;
                  busy_q      <= 1'b1;
                  init_done_q <= 1'b0;
               end else if (clr_req) begin
                  state_q     <= ST_WIN;
                  win_idx_q   <= 4'd0;
                  busy_q      <= 1'b1;
                  init_done_q <= 1'b0;
               end else begin
                  busy_q      <= 1'b0;
                  init_done_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_RST_LOW;
               lcd_rst_q   <= 1'b0;
               cnt_q       <= '0;
               en_write_q  <= 1'b0;
               init_data_q <= 9'h100;
               busy_q      <= 1'b1;
               init_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign tbl_addr  = tbl_addr_q;
   assign lcd_rst   = lcd_rst_q;
   assign init_data = init_data_q;
   assign en_write  = en_write_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq: a byte-writer model with fixed latency,
// a small table ROM, and hand-written expected byte streams per scenario.
module tb_lcd_init_seq;

   localparam int LAT = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        wr_done;
   logic [1:0]  tbl_addr;
   logic [9:0]  tbl_data;
   logic [15:0] clr_color;
   logic        reinit;
   logic        clr_req;
   logic        lcd_rst;
   logic [8:0]  init_data;
   logic        en_write;
   logic        busy;
   logic        init_done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [9:0]  rom [4];
   logic [8:0]  got [$];
   int          gaps [$];
   logic [8:0]  exp_q [$];
   int          stab_err = 0;
   int          hs_err   = 0;
   int          rst_fell = 0;
   int          r0;

   lcd_init_seq #(
      .RST_LOW_CYC (10),
      .RST_HIGH_CYC(10),
      .SLPOUT_CYC  (5),
      .DLY_UNIT_CYC(4),
      .TBL_LEN     (4),
      .WIDTH       (4),
      .HEIGHT      (2),
      .X_OFS       (2),
      .Y_OFS       (1)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .wr_done  (wr_done),
      .tbl_addr (tbl_addr),
      .tbl_data (tbl_data),
      .clr_color(clr_color),
      .reinit   (reinit),
      .clr_req  (clr_req),
      .lcd_rst  (lcd_rst),
      .init_data(init_data),
      .en_write (en_write),
      .busy     (busy),
      .init_done(init_done)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) tbl_data <= rom[tbl_addr];

   always @(negedge lcd_rst) rst_fell <= rst_fell + 1;

   // Writer model: acknowledges each byte LAT cycles after it appears.
   initial begin
      int hold;
      int low_run;
      logic [8:0] first;
      hold = 0;
      low_run = 0;
      first = 9'h000;
      wr_done = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (wr_done) begin
            wr_done = 1'b0;
            if (en_write) hs_err++;
            else low_run++;
         end else if (en_write && sys_rst_n) begin
            if (hold == 0) begin
               gaps.push_back(low_run);
               first = init_data;
            end else if (init_data !== first) begin
               stab_err++;
            end
            low_run = 0;
            hold++;
            if (hold == LAT) begin
               wr_done = 1'b1;
               got.push_back(init_data);
               hold = 0;
            end
         end else begin
            hold = 0;
            low_run++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (init_done !== 1'b1 && n < budget) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      check_eq(tag, {31'd0, init_done}, 32'd1);
   endtask

   task automatic wait_bytes(input string tag, input int cnt, input int budget);
      int n;
      n = 0;
      while (got.size() < cnt && n < budget) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      check_eq(tag, {31'd0, got.size() >= cnt}, 32'd1);
   endtask

   task automatic pulse_reinit();
      @(negedge sys_clk);
      reinit = 1'b1;
      @(negedge sys_clk);
      reinit = 1'b0;
   endtask

   task automatic push_win_fill(input logic [15:0] c);
      exp_q.push_back(9'h02A); exp_q.push_back(9'h100); exp_q.push_back(9'h102);
      exp_q.push_back(9'h100); exp_q.push_back(9'h105);
      exp_q.push_back(9'h02B); exp_q.push_back(9'h100); exp_q.push_back(9'h101);
      exp_q.push_back(9'h100); exp_q.push_back(9'h102);
      exp_q.push_back(9'h02C);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({1'b1, c[15:8]});
         exp_q.push_back({1'b1, c[7:0]});
      end
   endtask

   task automatic compare_stream(input string tag);
      logic [31:0] obs;
      check_eq({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? {23'd0, got[i]} : 32'hDEAD;
         check_eq($sformatf("%s[%0d]", tag, i), obs, {23'd0, exp_q[i]});
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_lcd_rst"}, {31'd0, lcd_rst}, 32'd0);
      check_eq({tag, "_init_data"}, {23'd0, init_data}, 32'h100);
      check_eq({tag, "_en_write"}, {31'd0, en_write}, 32'd0);
      check_eq({tag, "_tbl_addr"}, {30'd0, tbl_addr}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      reinit    = 1'b0;
      clr_req   = 1'b0;
      clr_color = 16'hF800;
      rom[0] = 10'h0B1; rom[1] = 10'h105; rom[2] = 10'h300; rom[3] = 10'h000;

      // Power-up with table {00:B1, 01:05, 11:xx}; colour changes mid-fill.
      #23;
      check_reset_vals("rst");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (9) @(posedge sys_clk);
      #1 check_eq("lcd_rst_low_9", {31'd0, lcd_rst}, 32'd0);
      @(posedge sys_clk);
      #1 check_eq("lcd_rst_high_10", {31'd0, lcd_rst}, 32'd1);
      wait_bytes("pwrup_fill_started", 18, 2000);
      clr_color = 16'h1234;
      wait_done("pwrup_done", 2000);
      check_eq("pwrup_busy", {31'd0, busy}, 32'd0);
      check_eq("pwrup_en_idle", {31'd0, en_write}, 32'd0);
      exp_q.delete();
      exp_q.push_back(9'h011); exp_q.push_back(9'h0B1); exp_q.push_back(9'h105);
      push_win_fill(16'hF800);
      compare_stream("pwrup");
      check_eq("nodly_gap_short", {31'd0, gaps.size() > 2 && gaps[2] < 12}, 32'd1);

      // Clear request; a reinit during the fill must be dropped.
      got.delete(); gaps.delete();
      r0 = rst_fell;
      clr_color = 16'h001F;
      @(negedge sys_clk);
      clr_req = 1'b1;
      @(posedge sys_clk);
      #1 check_eq("clr_busy", {31'd0, busy}, 32'd1);
      check_eq("clr_done_low", {31'd0, init_done}, 32'd0);
      @(negedge sys_clk);
      clr_req = 1'b0;
      wait_bytes("clr_in_fill", 14, 2000);
      pulse_reinit();
      wait_done("clr_done", 2000);
      check_eq("clr_no_lcd_rst", rst_fell - r0, 32'd0);
      exp_q.delete();
      push_win_fill(16'h001F);
      compare_stream("clr");

      // Reinit and clear together; table with a 3-unit delay.
      rom[0] = 10'h0B1; rom[1] = 10'h203; rom[2] = 10'h105; rom[3] = 10'h300;
      got.delete(); gaps.delete();
      clr_color = 16'h00FF;
      @(negedge sys_clk);
      reinit = 1'b1;
      clr_req = 1'b1;
      @(posedge sys_clk);
      #1 check_eq("both_lcd_rst", {31'd0, lcd_rst}, 32'd0);
      check_eq("both_busy", {31'd0, busy}, 32'd1);
      @(negedge sys_clk);
      reinit = 1'b0;
      clr_req = 1'b0;
      wait_done("dly_done", 2000);
      exp_q.delete();
      exp_q.push_back(9'h011); exp_q.push_back(9'h0B1); exp_q.push_back(9'h105);
      push_win_fill(16'h00FF);
      compare_stream("dly");
      check_eq("dly_gap_ge12", {31'd0, gaps.size() > 2 && gaps[2] >= 12}, 32'd1);

      // No end marker: all four entries are data, then the window follows.
      rom[0] = 10'h1AA; rom[1] = 10'h1BB; rom[2] = 10'h1CC; rom[3] = 10'h1DD;
      got.delete(); gaps.delete();
      clr_color = 16'hA5C3;
      pulse_reinit();
      wait_done("noend_done", 2000);
      exp_q.delete();
      exp_q.push_back(9'h011); exp_q.push_back(9'h1AA); exp_q.push_back(9'h1BB);
      exp_q.push_back(9'h1CC); exp_q.push_back(9'h1DD);
      push_win_fill(16'hA5C3);
      compare_stream("noend");

      // Asynchronous reset in the middle of the fill.
      got.delete(); gaps.delete();
      pulse_reinit();
      wait_bytes("arst_in_fill", 20, 2000);
      @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 check_reset_vals("arst");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (9) @(posedge sys_clk);
      #1 check_eq("arst_lcd_rst_low_9", {31'd0, lcd_rst}, 32'd0);
      @(posedge sys_clk);
      #1 check_eq("arst_lcd_rst_high_10", {31'd0, lcd_rst}, 32'd1);

      check_eq("data_stable", stab_err, 32'd0);
      check_eq("en_drop_after_done", hs_err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
